// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with byte-lane writes, selectable
// read-during-write behaviour, an optional output register and a clear engine
// that zeroes the whole array after reset or on request.
module ram_sp_param #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 6,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned WRITE_MODE     = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     din,
    input  logic                  clr,
    output logic [DATA_W-1:0]     dout,
    output logic                  dout_valid,
    output logic                  busy
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;

    logic                clear_we;
    logic                acc;
    logic                wr;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rword;
    logic [DATA_W-1:0]   mword;
    logic [DATA_W-1:0]   rdata;

    logic                s1_v_q;
    logic [DATA_W-1:0]   s1_d_q;

    // State register: reset aborts any clear and restarts the engine from word 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? StClear : StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: clr only honoured in idle; clear walks every word once
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (clr) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output/decode logic: clr beats a same-cycle access, busy drops accesses
    always_comb begin
        busy     = (state_q == StClear);
        clear_we = (state_q == StClear) && rst;
        acc      = rst && en && (state_q == StIdle) && !clr;
        wr       = acc && we;
    end

    // Read word and byte-merged write word for the write-first return path
    always_comb begin
        rword = mem[addr];
        mword = rword;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                mword[8*i +: 8] = din[8*i +: 8];
            end
        end
        rdata = (we && (WRITE_MODE != 0)) ? mword : rword;
    end

    // Array update: clear engine has priority; array itself is never reset
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[cnt_q] <= '0;
        end else if (wr) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    // First read stage: data only loads on a served access so it holds otherwise
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_v_q <= 1'b0;
            s1_d_q <= '0;
        end else begin
            s1_v_q <= acc;
            if (acc) begin
                s1_d_q <= rdata;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic              s2_v_q;
        logic [DATA_W-1:0] s2_d_q;

        // Second output stage adds one cycle of latency, still fully pipelined
        always_ff @(posedge clk) begin
            if (!rst) begin
                s2_v_q <= 1'b0;
                s2_d_q <= '0;
            end else begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    s2_d_q <= s1_d_q;
                end
            end
        end

        assign dout       = s2_d_q;
        assign dout_valid = s2_v_q;
    end else begin : g_noreg
        assign dout       = s1_d_q;
        assign dout_valid = s1_v_q;
    end

endmodule
